// File: rtl/fc_bias_argmax_if.sv
// ---------------------------------------------------------------------------
// fc_bias_argmax_if
// Purpose : bundles the data-side signals of the FC output stage.
//   i_bias      packed bias vector, neuron k at [k*BW +: BW]
//   i_bias_full bias vector is loaded and valid
//   i_valid     i_acc valid this cycle
//   i_acc       signed accumulator result for the current neuron
//   o_valid     one-cycle pulse, o_data/o_idx valid
//   o_data      biased, saturated, optionally ReLU'd neuron output
//   o_idx       neuron index of o_data
//   o_done      pulse on the last o_valid of a frame
//   o_class     argmax index, updated with o_done
//   o_err       sticky: i_valid seen while i_bias_full = 0
// Modports: slave = the block itself, master = whoever drives it.
// ---------------------------------------------------------------------------
interface fc_bias_argmax_if #(
    parameter int BW   = 16,
    parameter int ABW  = 32,
    parameter int SIZE = 10
);
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [BW*SIZE-1:0] i_bias;
    logic               i_bias_full;
    logic               i_valid;
    logic [ABW-1:0]     i_acc;
    logic               o_valid;
    logic [BW-1:0]      o_data;
    logic [IW-1:0]      o_idx;
    logic               o_done;
    logic [IW-1:0]      o_class;
    logic               o_err;

    modport slave (
        input  i_bias, i_bias_full, i_valid, i_acc,
        output o_valid, o_data, o_idx, o_done, o_class, o_err
    );

    modport master (
        output i_bias, i_bias_full, i_valid, i_acc,
        input  o_valid, o_data, o_idx, o_done, o_class, o_err
    );
endinterface

// File: rtl/fc_bias_argmax.sv
// ---------------------------------------------------------------------------
// fc_bias_argmax
// Purpose : output stage of the fully-connected layer. Per accepted neuron
//   the accumulator is rescaled (>>> FRAC), the neuron's bias is added, the
//   sum is saturated to BW bits and optionally ReLU'd. A running maximum of
//   the saturated (pre-ReLU) values yields the class index after SIZE
//   neurons.
// Ports:
//   clk          rising-edge clock
//   global_rst_n synchronous active-low reset (highest priority)
//   user_reset   synchronous active-high soft reset
//   ce           clock enable
//   bus          fc_bias_argmax_if.slave, data inputs and registered outputs
// ---------------------------------------------------------------------------
module fc_bias_argmax #(
    parameter int BW   = 16,
    parameter int ABW  = 32,
    parameter int SIZE = 10,
    parameter int FRAC = 8,
    parameter bit RELU = 1'b1
) (
    input  logic                  clk,
    input  logic                  global_rst_n,
    input  logic                  user_reset,
    input  logic                  ce,
    fc_bias_argmax_if.slave       bus
);
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    // Saturation bounds expressed at the ABW+1 bit sum width.
    localparam logic signed [ABW:0] SUM_HI = {{(ABW-BW+2){1'b0}}, {(BW-1){1'b1}}};
    localparam logic signed [ABW:0] SUM_LO = {{(ABW-BW+2){1'b1}}, {(BW-1){1'b0}}};
    localparam logic [BW-1:0]       SAT_HI = {1'b0, {(BW-1){1'b1}}};
    localparam logic [BW-1:0]       SAT_LO = {1'b1, {(BW-1){1'b0}}};
    localparam logic [IW-1:0]       LAST   = IW'(SIZE-1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_cnt;
    logic [BW-1:0]   r_max;
    logic [IW-1:0]   r_max_idx;
    logic            r_valid;
    logic [BW-1:0]   r_data;
    logic [IW-1:0]   r_idx;
    logic            r_done;
    logic [IW-1:0]   r_class;
    logic            r_err;

    logic                  w_accept;
    logic [BW-1:0]         w_bias;
    logic signed [ABW-1:0] w_shift;
    logic signed [ABW:0]   w_sum;
    logic [BW-1:0]         w_sat;
    logic [BW-1:0]         w_out;
    logic                  w_first;
    logic                  w_new_max;
    logic                  w_last;

    always_comb begin
        w_accept = ce && bus.i_valid && bus.i_bias_full;
        w_bias   = bus.i_bias[int'(r_cnt)*BW +: BW];
        w_shift  = $signed(bus.i_acc) >>> FRAC;
        // One extra bit of headroom means the add itself can never wrap.
        w_sum    = $signed({w_shift[ABW-1], w_shift})
                 + $signed({{(ABW+1-BW){w_bias[BW-1]}}, w_bias});
        if (w_sum > SUM_HI)
            w_sat = SAT_HI;
        else if (w_sum < SUM_LO)
            w_sat = SAT_LO;
        else
            w_sat = w_sum[BW-1:0];
        w_out     = (RELU && w_sat[BW-1]) ? '0 : w_sat;
        // IDLE means counter 0: the first neuron of a frame always seeds the max.
        w_first   = (r_state == IDLE);
        // Strict compare keeps the lower index on ties.
        w_new_max = w_first || ($signed(w_sat) > $signed(r_max));
        w_last    = (r_cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (!global_rst_n || user_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_max     <= '0;
            r_max_idx <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_idx     <= '0;
            r_done    <= 1'b0;
            r_class   <= '0;
            r_err     <= 1'b0;
        end else if (ce) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            // Dropped sample: counter untouched, error latched until reset.
            if (bus.i_valid && !bus.i_bias_full)
                r_err <= 1'b1;
            if (w_accept) begin
                r_valid <= 1'b1;
                r_data  <= w_out;
                r_idx   <= r_cnt;
                if (w_new_max) begin
                    r_max     <= w_sat;
                    r_max_idx <= r_cnt;
                end
                if (w_last) begin
                    r_done  <= 1'b1;
                    r_class <= w_new_max ? r_cnt : r_max_idx;
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= RUN;
                end
            end
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end
    end

    assign bus.o_valid = r_valid;
    assign bus.o_data  = r_data;
    assign bus.o_idx   = r_idx;
    assign bus.o_done  = r_done;
    assign bus.o_class = r_class;
    assign bus.o_err   = r_err;

endmodule

// File: tb/tb_fc_bias_argmax.sv
// ---------------------------------------------------------------------------
// tb_fc_bias_argmax
// Directed stimulus driving fc_bias_argmax. A frame-level model (saturating
// arithmetic on integers, argmax over the list of sats of the frame) builds
// the expected outputs after each edge; one negedge process compares every
// output every cycle, and a few literal values pin the model.
// ---------------------------------------------------------------------------
module tb_fc_bias_argmax;
    localparam int BW   = 16;
    localparam int ABW  = 32;
    localparam int SIZE = 10;
    localparam int FRAC = 8;
    localparam bit RELU = 1'b1;

    logic clk = 1'b0;
    logic global_rst_n;
    logic user_reset;
    logic ce;

    fc_bias_argmax_if #(.BW(BW), .ABW(ABW), .SIZE(SIZE)) bif ();

    fc_bias_argmax #(.BW(BW), .ABW(ABW), .SIZE(SIZE), .FRAC(FRAC), .RELU(RELU)) dut (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .user_reset   (user_reset),
        .ce           (ce),
        .bus          (bif.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // ---------------- model ----------------
    logic [BW-1:0] bias_arr [SIZE];
    int  m_cnt;
    int  sats [$];
    logic         e_valid, e_done, e_err;
    logic [BW-1:0] e_data;
    logic [31:0]  e_idx, e_class;

    function automatic int satf(input logic [ABW-1:0] a, input logic [BW-1:0] b);
        longint s;
        longint lo, hi;
        s  = (longint'($signed(a)) >>> FRAC) + longint'($signed(b));
        hi = (longint'(1) <<< (BW-1)) - 1;
        lo = -(longint'(1) <<< (BW-1));
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return int'(s);
    endfunction

    function automatic int argmax_first(input int q [$]);
        int best = 0;
        for (int i = 1; i < q.size(); i++)
            if (q[i] > q[best]) best = i;
        return best;
    endfunction

    task automatic load_bias();
        for (int k = 0; k < SIZE; k++) bif.i_bias[k*BW +: BW] = bias_arr[k];
    endtask

    // One clock: drive inputs, take the edge, advance the model.
    task automatic cyc(input bit c, input bit v, input logic [ABW-1:0] a,
                       input bit full, input bit ur, input bit grn);
        int s;
        ce = c; bif.i_valid = v; bif.i_acc = a; bif.i_bias_full = full;
        user_reset = ur; global_rst_n = grn;
        load_bias();
        @(posedge clk);
        #1;
        if (!grn || ur) begin
            e_valid = 0; e_done = 0; e_err = 0; e_data = '0; e_idx = 0; e_class = 0;
            m_cnt = 0; sats.delete();
        end else if (c) begin
            e_valid = 0; e_done = 0;
            if (v && !full) e_err = 1;
            else if (v) begin
                s = satf(a, bias_arr[m_cnt]);
                sats.push_back(s);
                e_valid = 1;
                e_data  = (RELU && s < 0) ? '0 : BW'(s);
                e_idx   = m_cnt;
                m_cnt++;
                if (m_cnt == SIZE) begin
                    e_done  = 1;
                    e_class = argmax_first(sats);
                    sats.delete();
                    m_cnt = 0;
                end
            end
        end else begin
            e_valid = 0; e_done = 0;
        end
    endtask

    task automatic acc(input logic [ABW-1:0] a);
        cyc(1, 1, a, 1, 0, 1);
    endtask

    task automatic idle();
        cyc(1, 0, '0, 1, 0, 1);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("o_valid", 32'(bif.o_valid), 32'(e_valid));
            chk("o_done",  32'(bif.o_done),  32'(e_done));
            chk("o_err",   32'(bif.o_err),   32'(e_err));
            chk("o_data",  32'(bif.o_data),  32'(e_data));
            chk("o_idx",   32'(bif.o_idx),   e_idx);
            chk("o_class", 32'(bif.o_class), e_class);
        end
    end

    initial begin
        for (int k = 0; k < SIZE; k++) bias_arr[k] = '0;
        m_cnt = 0;
        cyc(0, 0, '0, 0, 0, 0);
        cyc(0, 0, '0, 0, 0, 0);
        chk_en = 1'b1;
        chk("rst_valid", 32'(bif.o_valid), 0);
        chk("rst_class", 32'(bif.o_class), 0);

        // Basic bias add and argmax.
        for (int k = 0; k < SIZE; k++) bias_arr[k] = 16'h0100;
        for (int k = 0; k < SIZE; k++) begin
            acc((k == 6) ? 32'h0005_0000 : 32'h0002_0000);
            if (k == 0) chk("lit_d0", 32'(bif.o_data), 32'h0300);
            if (k == 6) chk("lit_d6", 32'(bif.o_data), 32'h0600);
        end
        chk("lit_done", 32'(bif.o_done), 1);
        chk("lit_cls6", 32'(bif.o_class), 6);
        idle();
        chk("lit_hold", 32'(bif.o_class), 6);

        // Positive saturation at k=0.
        for (int k = 0; k < SIZE; k++) bias_arr[k] = '0;
        bias_arr[0] = 16'h7FFF;
        acc(32'h7FFF_FF00);
        chk("lit_satp", 32'(bif.o_data), 32'h7FFF);
        for (int k = 1; k < SIZE; k++) acc(32'h0);
        chk("lit_cls0", 32'(bif.o_class), 0);

        // Negative saturation + ReLU; argmax sees -32768, so -5 at k=1 wins.
        bias_arr[0] = 16'h8000;
        acc(32'h8000_0000);
        chk("lit_relu", 32'(bif.o_data), 0);
        for (int k = 1; k < SIZE; k++) acc(32'hFFFF_FB00);
        chk("lit_clsneg", 32'(bif.o_class), 1);

        // All-equal negative frame.
        bias_arr[0] = '0;
        for (int k = 0; k < SIZE; k++) acc(32'hFFFF_FB00);
        chk("lit_tie0", 32'(bif.o_class), 0);

        // Equal maxima at k=3 and k=7.
        for (int k = 0; k < SIZE; k++) acc((k == 3 || k == 7) ? 32'h0001_0000 : 32'h0);
        chk("lit_tie3", 32'(bif.o_class), 3);

        // Bias not ready.
        cyc(1, 1, 32'h0002_0000, 0, 0, 1);
        chk("lit_nrv", 32'(bif.o_valid), 0);
        chk("lit_err", 32'(bif.o_err), 1);
        for (int k = 0; k < SIZE; k++) acc(32'h0002_0000 + 32'(k) * 32'h100);
        chk("lit_errcls", 32'(bif.o_class), 9);
        chk("lit_errhold", 32'(bif.o_err), 1);

        // ce gating mid-frame.
        for (int k = 0; k < 4; k++) acc(32'h0001_0000);
        for (int k = 0; k < 3; k++) cyc(0, 1, 32'h0009_0000, 1, 0, 1);
        acc(32'h0003_0000);
        chk("lit_ceidx", 32'(bif.o_idx), 4);
        for (int k = 5; k < SIZE; k++) acc(32'h0001_0000);
        chk("lit_cecls", 32'(bif.o_class), 4);

        // user_reset after 4 accepts, then a full frame.
        for (int k = 0; k < 4; k++) acc(32'h0007_0000);
        cyc(1, 1, 32'h0007_0000, 1, 1, 1);
        chk("lit_urcls", 32'(bif.o_class), 0);
        chk("lit_urerr", 32'(bif.o_err), 0);
        for (int k = 0; k < SIZE; k++) begin
            acc((k == 8) ? 32'h0004_0000 : 32'h0001_0000);
            if (k == SIZE-2) chk("lit_urnodone", 32'(bif.o_done), 0);
        end
        chk("lit_urdone", 32'(bif.o_done), 1);
        chk("lit_urcls8", 32'(bif.o_class), 8);

        // Global reset for one cycle.
        cyc(1, 1, 32'h0001_0000, 1, 0, 0);
        chk("lit_grdata", 32'(bif.o_data), 0);
        chk("lit_grcls", 32'(bif.o_class), 0);
        idle();
        idle();

        chk_en = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
